// File: rtl/tusca_pkg.sv
// State codes and widths shared by the TUSCA control unit and its testbench.
package tusca_pkg;

  localparam int ESTADO_W = 4;

  localparam logic [ESTADO_W-1:0] INICIAL       = 4'd0;
  localparam logic [ESTADO_W-1:0] CONFIG        = 4'd1;
  localparam logic [ESTADO_W-1:0] ERRO_CFG      = 4'd2;
  localparam logic [ESTADO_W-1:0] ZERA          = 4'd3;
  localparam logic [ESTADO_W-1:0] MEDE          = 4'd4;
  localparam logic [ESTADO_W-1:0] ESPERA_MEDIDA = 4'd5;
  localparam logic [ESTADO_W-1:0] FALHA         = 4'd6;
  localparam logic [ESTADO_W-1:0] ESPERA_DELAY  = 4'd7;
  localparam logic [ESTADO_W-1:0] ERRO_MED      = 4'd8;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter that stops at M-1 instead of wrapping; fim flags the terminal count.
module contador_m #(
  parameter int M = 100,
  parameter int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] cnt_q;

  // Holding at M-1 keeps fim asserted until the counter is explicitly cleared.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      cnt_q <= '0;
    end else if (zera_s) begin
      cnt_q <= '0;
    end else if (conta && (cnt_q != N'(M - 1))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fim = (cnt_q == N'(M - 1));

endmodule

// File: rtl/tusca_uc.sv
// TUSCA control unit: Moore FSM sequencing configuration, DHT11 measurement with
// timeout and bounded retry, inter-measurement delay and servo enable.
module tusca_uc
  import tusca_pkg::*;
#(
  parameter int TIMEOUT_MEDIDA = 50_000_000,
  parameter int MAX_FALHAS     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                reconfigurar,
  input  logic                pronto_config,
  input  logic                erro_config,
  input  logic                pronto_medida,
  input  logic                fim_delay,
  output logic                receber_config,
  output logic                medir_dht11,
  output logic                zera_delay,
  output logic                conta_delay,
  output logic                gira,
  output logic                erro_medida,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int FW = $clog2(MAX_FALHAS + 1);

  logic [ESTADO_W-1:0] estado_q, estado_d;
  logic [FW-1:0]       falhas_q, falhas_d;
  logic                pedido_cfg_q, pedido_cfg_d;
  logic                timeout;

  // zera_as stays low so the counter only ever clears synchronously.
  contador_m #(.M(TIMEOUT_MEDIDA)) u_timeout (
    .clock   (clock),
    .zera_as (1'b0),
    .zera_s  (reset || (estado_q == ZERA)),
    .conta   (estado_q == ESPERA_MEDIDA),
    .fim     (timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      falhas_q     <= '0;
      pedido_cfg_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      falhas_q     <= falhas_d;
      pedido_cfg_q <= pedido_cfg_d;
    end
  end

  always_comb begin
    estado_d       = estado_q;
    falhas_d       = falhas_q;
    pedido_cfg_d   = pedido_cfg_q;
    receber_config = 1'b0;
    medir_dht11    = 1'b0;
    zera_delay     = 1'b0;
    conta_delay    = 1'b0;
    gira           = 1'b0;
    erro_medida    = 1'b0;

    // Reconfiguration is only remembered while the measurement loop is running.
    if (reconfigurar && (estado_q >= ZERA) && (estado_q <= ESPERA_DELAY)) begin
      pedido_cfg_d = 1'b1;
    end

    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = CONFIG;
      end
      CONFIG: begin
        receber_config = 1'b1;
        if (erro_config)        estado_d = ERRO_CFG;
        else if (pronto_config) estado_d = ZERA;
      end
      ERRO_CFG: begin
        if (iniciar) estado_d = CONFIG;
      end
      ZERA: begin
        zera_delay = 1'b1;
        gira       = 1'b1;
        estado_d   = MEDE;
      end
      MEDE: begin
        medir_dht11 = 1'b1;
        gira        = 1'b1;
        estado_d    = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        gira = 1'b1;
        if (pronto_medida) begin
          estado_d = ESPERA_DELAY;
          falhas_d = '0;
        end else if (timeout) begin
          estado_d = FALHA;
        end
      end
      FALHA: begin
        gira     = 1'b1;
        falhas_d = falhas_q + 1'b1;
        estado_d = (falhas_d == FW'(MAX_FALHAS)) ? ERRO_MED : ZERA;
      end
      ESPERA_DELAY: begin
        conta_delay = 1'b1;
        gira        = 1'b1;
        if (pedido_cfg_q)   estado_d = CONFIG;
        else if (fim_delay) estado_d = ZERA;
      end
      ERRO_MED: begin
        erro_medida = 1'b1;
        if (iniciar) begin
          estado_d = ZERA;
          falhas_d = '0;
        end
      end
      default: estado_d = INICIAL;
    endcase

    if (estado_d == CONFIG) pedido_cfg_d = 1'b0;
  end

  assign db_estado = estado_q;

endmodule
